// File: rtl/muxn_rr_reg.sv
// muxn_rr_reg: N:1, WIDTH-bit multiplexer with valid/ready handshake and one
// registered output stage. The select is either manual (sel) or round-robin
// over the requesting channels.
// Optional build macro MUXN_RR_XFER_CNT_EN adds a saturating 16-bit counter of
// output handshakes on port xfer_cnt.

// Per-channel slice: qualifies the grant into this channel's ready bit and
// masks its data so the output can be formed by a plain OR across channels.
// Data from a channel that is not granted is forced to zero, so X or garbage
// on an unselected channel never reaches the output register.
module muxn_rr_lane #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 2,
  parameter int LANE  = 0
) (
  input  logic             gnt_vld,
  input  logic [SEL_W-1:0] gnt_idx,
  input  logic             load_en,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] data_o
);
  logic hit;
  assign hit     = gnt_vld && (gnt_idx == SEL_W'(LANE));
  assign ready_o = hit && load_en && rst_n;
  assign data_o  = hit ? data_i : '0;
endmodule

module muxn_rr_reg #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [$clog2(NUM_IN)-1:0] sel,
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  input  logic [NUM_IN-1:0]         in_valid,
  output logic [NUM_IN-1:0]         in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [$clog2(NUM_IN)-1:0] out_src,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef MUXN_RR_XFER_CNT_EN
  ,
  output logic [15:0]               xfer_cnt
`endif
);
  localparam int SEL_W = $clog2(NUM_IN);

  // Output stage occupancy
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [SEL_W-1:0] src_q,   src_d;
  logic [SEL_W-1:0] ptr_q,   ptr_d;

  logic [NUM_IN-1:0][WIDTH-1:0] in_arr;
  logic [NUM_IN-1:0][WIDTH-1:0] lane_data;
  logic [WIDTH-1:0]             sel_data;
  logic                         gnt_vld;
  logic [SEL_W-1:0]             gnt_idx;
  logic                         load_en;
  logic                         xfer;
  int                           rr_idx;

  assign in_arr  = in_data;
  // Stage can take a beat when empty, or when the held beat leaves this edge.
  assign load_en = (state_q == EMPTY) || out_ready;
  assign xfer    = gnt_vld && load_en;

  // Grant selection: manual index, or first requester at/after ptr with wrap.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_idx  = 0;
    if (!mode) begin
      // An out-of-range sel matches no channel, so it never grants.
      for (int i = 0; i < NUM_IN; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = SEL_W'(i);
        end
      end
    end else begin
      // Walk offsets from farthest to nearest so the nearest requester wins.
      for (int k = NUM_IN - 1; k >= 0; k--) begin
        rr_idx = int'(ptr_q) + k;
        if (rr_idx >= NUM_IN) rr_idx = rr_idx - NUM_IN;
        if (in_valid[SEL_W'(rr_idx)]) begin
          gnt_vld = 1'b1;
          gnt_idx = SEL_W'(rr_idx);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_IN; g++) begin : g_lane
    muxn_rr_lane #(
      .WIDTH (WIDTH),
      .SEL_W (SEL_W),
      .LANE  (g)
    ) u_lane (
      .gnt_vld (gnt_vld),
      .gnt_idx (gnt_idx),
      .load_en (load_en),
      .rst_n   (rst_n),
      .data_i  (in_arr[g]),
      .ready_o (in_ready[g]),
      .data_o  (lane_data[g])
    );
  end

  // AND-OR data mux: at most one lane contributes non-zero data.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) sel_data = sel_data | lane_data[i];
  end

  // Next state of the output stage and the round-robin pointer.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      state_d = FULL;
      data_d  = sel_data;
      src_d   = gnt_idx;
      // Only round-robin transfers move the pointer; manual ones leave it.
      if (mode) ptr_d = (gnt_idx == SEL_W'(NUM_IN - 1)) ? '0 : gnt_idx + SEL_W'(1);
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end
  end

  // Output register and pointer; reset discards any held beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;

`ifdef MUXN_RR_XFER_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Saturating count of beats accepted downstream.
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign xfer_cnt = cnt_q;
`endif
endmodule
